// File: rtl/image_uart_pkg.sv
// Shared constants and state encodings for the image UART return path.
package image_uart_pkg;

  localparam int HDR_BYTES            = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PIX  = 2'd2,
    FIN  = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_t;

  // Header byte order on the wire: height MSB, height LSB, width MSB, width LSB.
  function automatic logic [7:0] hdr_byte(input logic [1:0]  idx,
                                          input logic [15:0] h,
                                          input logic [15:0] w);
    logic [7:0] b;
    case (idx)
      2'd0:    b = h[15:8];
      2'd1:    b = h[7:0];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. Reports idle during the last stop-bit cycle so a
// following byte can start without a gap.
module uart_tx_byte
  import image_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  ser_state_t  r_state, w_state_nxt;
  logic [15:0] r_cnt,   w_cnt_nxt;
  logic [2:0]  r_bit,   w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_tx,    w_tx_nxt;
  logic        w_bit_end;

  assign w_bit_end = (r_cnt == LAST_CNT);
  assign idle      = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);
  assign tx        = r_tx;

  // State register; reset forces the line high even mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Bit sequencing: start, 8 data bits LSB first, stop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = 16'd0;
          w_shift_nxt = data;
          w_tx_nxt    = 1'b0;
        end else begin
          w_tx_nxt    = 1'b1;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = 16'd0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = 16'd0;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = 16'd0;
          if (load) begin
            w_state_nxt = S_START;
            w_shift_nxt = data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 16'd0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/image_uart_tx.sv
// Frame sequencer: sends a 4-byte size header then height*width pixel bytes
// through the byte serializer.
module image_uart_tx
  import image_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PIX_CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] height,
  input  logic [15:0] width,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0] LAST_HDR = 2'(HDR_BYTES - 1);

  frame_state_t         r_state,      w_state_nxt;
  logic [15:0]          r_height,     w_height_nxt;
  logic [15:0]          r_width,      w_width_nxt;
  logic [PIX_CNT_W-1:0] r_total,      w_total_nxt;
  logic [PIX_CNT_W-1:0] r_sent,       w_sent_nxt;
  logic [1:0]           r_hdr_idx,    w_hdr_idx_nxt;
  logic                 r_busy,       w_busy_nxt;
  logic                 r_frame_done, w_frame_done_nxt;
  logic                 w_ser_load;
  logic [7:0]           w_ser_data;
  logic                 w_ser_idle;
  logic                 w_ser_tx;
  logic                 w_pixel_ready;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (w_ser_load),
    .data  (w_ser_data),
    .tx    (w_ser_tx),
    .idle  (w_ser_idle)
  );

  // Depends only on registered state, never on pixel_valid.
  assign w_pixel_ready = (r_state == PIX) && w_ser_idle && (r_sent < r_total);
  assign pixel_ready   = w_pixel_ready;
  assign tx            = w_ser_tx;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

  // Frame state and latched geometry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_height     <= 16'd0;
      r_width      <= 16'd0;
      r_total      <= '0;
      r_sent       <= '0;
      r_hdr_idx    <= 2'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_height     <= w_height_nxt;
      r_width      <= w_width_nxt;
      r_total      <= w_total_nxt;
      r_sent       <= w_sent_nxt;
      r_hdr_idx    <= w_hdr_idx_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Next-state logic and serializer feed.
  always_comb begin
    w_state_nxt      = r_state;
    w_height_nxt     = r_height;
    w_width_nxt      = r_width;
    w_total_nxt      = r_total;
    w_sent_nxt       = r_sent;
    w_hdr_idx_nxt    = r_hdr_idx;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_ser_load       = 1'b0;
    w_ser_data       = 8'h00;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_height_nxt  = height;
          w_width_nxt   = width;
          w_total_nxt   = PIX_CNT_W'(height) * PIX_CNT_W'(width);
          w_sent_nxt    = '0;
          w_hdr_idx_nxt = 2'd0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = HDR;
        end else begin
          w_busy_nxt    = 1'b0;
        end
      end
      HDR: begin
        if (w_ser_idle) begin
          w_ser_load    = 1'b1;
          w_ser_data    = hdr_byte(r_hdr_idx, r_height, r_width);
          w_hdr_idx_nxt = r_hdr_idx + 2'd1;
          if (r_hdr_idx == LAST_HDR) begin
            w_state_nxt = (r_total != '0) ? PIX : FIN;
          end else begin
            w_state_nxt = HDR;
          end
        end else begin
          w_ser_load    = 1'b0;
        end
      end
      PIX: begin
        if (pixel_valid && w_pixel_ready) begin
          w_ser_load = 1'b1;
          w_ser_data = pixel_in;
          w_sent_nxt = r_sent + PIX_CNT_W'(1);
          if ((r_sent + PIX_CNT_W'(1)) == r_total) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = PIX;
          end
        end else begin
          w_ser_load = 1'b0;
        end
      end
      FIN: begin
        // Idle here means the last stop bit is in its final cycle.
        if (w_ser_idle) begin
          w_frame_done_nxt = 1'b1;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = IDLE;
        end else begin
          w_frame_done_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/image_uart_tx.md
Name: image_uart_tx

Overview:
- Return path for processed images: serializes a frame header plus grayscale pixel bytes (e.g. sobel output) back to the host over UART, 8N1.
- Byte format is the inverse of the receive-side parser: 4 header bytes, then height*width pixel bytes, row-major.
- Runs on the system clock `clk`. No clock derived from the receiver.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
- PIX_CNT_W, 32, width of the pixel counter. Must be >= 32 for 16x16-bit products.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to send one frame; sampled only in IDLE
- height  input  16  frame height; latched when start is accepted
- width  input  16  frame width; latched when start is accepted
- pixel_in  input  8  grayscale pixel byte
- pixel_valid  input  1  pixel_in is valid
- pixel_ready  output  1  block accepts pixel_in this cycle
- tx  output  1  UART serial out; idle high
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last stop bit

Behaviour:
- Reset values: tx=1, busy=0, pixel_ready=0, frame_done=0. Frame FSM goes to IDLE, serializer goes to S_IDLE, all counters are cleared.
- Reset mid-operation aborts the frame. tx is 1 after the reset edge, even mid-bit. No partial byte is completed.
- Frame FSM states: IDLE -> HDR -> PIX -> FIN -> IDLE.
- IDLE:
  - start=1 at edge k: latch height/width, set busy=1 at edge k, and compute total = height*width (PIX_CNT_W bits, unsigned).
  - Go to HDR with hdr_idx=0.
- HDR: send 4 bytes in order: height[15:8], height[7:0], width[15:8], width[7:0].
  - Byte 0 loads at edge k+1, so tx=0 (start bit) from edge k+1.
  - After byte 3 is loaded: go to PIX if total!=0, else go to FIN.
- PIX:
  - pixel_ready = (state==PIX) && serializer idle && (sent < total). pixel_ready is driven from registers only.
  - A transfer happens at an edge where pixel_valid && pixel_ready. The byte loads into the serializer at that edge, tx=0 from that edge, and sent increments.
  - pixel_ready is 0 from the next cycle until the serializer returns to idle.
  - If pixel_valid is low while ready, tx stays high (idle). No timeout.
  - When sent==total and the serializer loads the last byte: go to FIN.
- FIN: wait for the serializer to go idle (end of the last stop bit). At that edge: frame_done=1 for one cycle, busy=0, state=IDLE.
- Serializer states: S_IDLE -> S_START -> S_DATA -> S_STOP -> S_IDLE.
  - Bit order: start bit 0, data bits LSB first, stop bit 1.
  - Every bit lasts exactly CLKS_PER_BIT cycles, so one byte is 10*CLKS_PER_BIT cycles.
  - Back-to-back: the serializer reports idle during the final cycle of the stop bit. A byte loaded then drives tx=0 on the very next edge, so there is no idle gap between header bytes.
- Simultaneous events:
  - start while busy is ignored. height/width are not re-latched.
  - reset has priority over everything.
  - start and reset together: reset wins.
- Arithmetic: total is the unsigned 32-bit product and never overflows. sent counts 0..total.

Decomposition:
- Shared package `image_uart_pkg`:
  - header byte count HDR_BYTES=4
  - frame FSM state enum
  - serializer state enum
  - default CLKS_PER_BIT
- One sub-module: `uart_tx_byte`.
  - Inputs: clk, reset, load, data[7:0].
  - Outputs: tx, idle.
  - Parameter: CLKS_PER_BIT.
  - Contains the bit-timing counter and bit index.
- `image_uart_tx` holds the frame FSM, header mux and pixel counter.

Test Plan:
1. CLKS_PER_BIT=4, start with height=2, width=3; pixels 0x10..0x15 always valid -> UART decode yields 00 02 00 03 10 11 12 13 14 15. Exactly 6 pixel handshakes. frame_done pulses once, 40 cycles after the final start-bit edge. busy=0 afterwards.
2. Bit timing with CLKS_PER_BIT=4 -> tx=0 from edge k+1 for exactly 4 cycles. Header bytes are contiguous, total 160 cycles. Bits are LSB first.
3. height=0, width=5 -> only 00 00 00 05 is sent, pixel_ready never rises, frame_done pulses after the 4th stop bit.
4. pixel_valid low for 50 cycles between pixels 2 and 3 -> tx holds 1 during the stall, pixel_ready stays 1, and the decoded byte stream is unchanged.
5. reset asserted mid-data-bit of pixel 1 -> tx=1, busy=0, pixel_ready=0 after that edge. A new start with 1x1 and pixel 0xA5 then sends 00 01 00 01 A5 cleanly.
6. start pulsed again during the header with height=9 -> ignored. The header still encodes the original 2x3 and only one frame_done is seen.
